keypad_scanner: RTL

//  Parametrised matrix-keypad scanner; next generation of the fixed 4x3 keypad FSM.
//  - Scans ROWS one-hot drive lines and samples COLS sense lines.
//  - Adds a per-row dwell timer, input synchronisers, and press/release debounce.
//  - Emits a one-cycle key_valid strobe per debounced press.
//  - Sits between the board keypad pins and the CPU input port / interrupt logic.

---
 rtl/keypad_scanner_if.sv | 18 +
 rtl/keypad_scanner.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: row drive and column sense pins on the keypad side,
// debounced key report (press, key_valid strobe, key_code) on the CPU side.
// master = scanner, slave = keypad pins / CPU input port.
interface keypad_scanner_if #(
  parameter int ROWS = 4,
  parameter int COLS = 3
);
  localparam int KEY_W = $clog2(ROWS*COLS+2);

  logic [COLS-1:0]  cols;
  logic [ROWS-1:0]  rows;
  logic             press;
  logic             key_valid;
  logic [KEY_W-1:0] key_code;

  modport master (input cols, output rows, press, key_valid, key_code);
  modport slave  (output cols, input rows, press, key_valid, key_code);
endinterface

// File: rtl/keypad_scanner.sv
// Parametrised matrix-keypad scanner with per-row dwell, 2-flop column
// synchroniser and press/release debounce. One key_valid strobe per accepted
// press; key_code = row*COLS+col+1 while held, ROWS*COLS+1 (NONE) otherwise.
// Optional feature macro: AUTOREPEAT_EN adds repeat strobes while a key is held
// (first after REPEAT_DLY cycles, then every REPEAT_RATE cycles).
module keypad_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 3,
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_CYCLES = 20000
`ifdef AUTOREPEAT_EN
  ,
  parameter int REPEAT_DLY  = 50_000_000,
  parameter int REPEAT_RATE = 10_000_000
`endif
) (
  input logic              clk,
  input logic              reset,
  keypad_scanner_if.master bus
);
  localparam int KEY_W = $clog2(ROWS*COLS+2);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW    = $clog2(SCAN_DIV+1);
  localparam int BW    = $clog2(DEB_CYCLES+1);
  localparam logic [KEY_W-1:0] NONE = KEY_W'(ROWS*COLS+1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t           state;
  logic [COLS-1:0]  cs_meta;
  logic [COLS-1:0]  cs;
  logic [RW-1:0]    row_idx;
  logic [RW-1:0]    next_row;
  logic [CW-1:0]    col_idx;
  logic [CW-1:0]    first_col;
  logic [DW-1:0]    dwell_cnt;
  logic [BW-1:0]    stab_cnt;
  logic [KEY_W-1:0] new_code;
  logic             col_on;

`ifdef AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int PW      = $clog2(REP_MAX+1);

  logic [PW-1:0] rep_cnt;
  logic [PW-1:0] rep_last;
  logic          repeating;

  // First repeat waits the long delay, later ones the shorter rate
  always_comb begin
    rep_last = repeating ? PW'(REPEAT_RATE-1) : PW'(REPEAT_DLY-1);
  end
`endif

  // Two-flop synchroniser for the asynchronous column sense lines
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_meta <= '0;
      cs      <= '0;
    end else begin
      cs_meta <= bus.cols;
      cs      <= cs_meta;
    end
  end

  // Lowest set column wins, next row wraps, code of the latched key
  always_comb begin
    first_col = '0;
    for (int i = COLS-1; i >= 0; i--) begin
      if (cs[i]) first_col = CW'(i);
    end
    next_row = (row_idx == RW'(ROWS-1)) ? '0 : row_idx + RW'(1);
    new_code = KEY_W'(int'(row_idx)*COLS + int'(col_idx) + 1);
    col_on   = cs[col_idx];
  end

  // Scan / debounce / held / release sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= SCAN;
      row_idx       <= '0;
      col_idx       <= '0;
      dwell_cnt     <= '0;
      stab_cnt      <= '0;
      bus.rows      <= ROWS'(1);
      bus.press     <= 1'b0;
      bus.key_valid <= 1'b0;
      bus.key_code  <= NONE;
`ifdef AUTOREPEAT_EN
      rep_cnt       <= '0;
      repeating     <= 1'b0;
`endif
    end else begin
      bus.key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (dwell_cnt == DW'(SCAN_DIV-1)) begin
            dwell_cnt <= '0;
            if (cs != '0) begin
              col_idx  <= first_col;
              stab_cnt <= '0;
              state    <= DEBOUNCE;
            end else begin
              row_idx  <= next_row;
              bus.rows <= ROWS'(1) << next_row;
            end
          end else begin
            dwell_cnt <= dwell_cnt + DW'(1);
          end
        end
        DEBOUNCE: begin
          if (!col_on) begin
            dwell_cnt <= '0;
            state     <= SCAN;
          end else if (stab_cnt == BW'(DEB_CYCLES-1)) begin
            state         <= HELD;
            bus.key_valid <= 1'b1;
            bus.press     <= 1'b1;
            bus.key_code  <= new_code;
`ifdef AUTOREPEAT_EN
            rep_cnt       <= '0;
            repeating     <= 1'b0;
`endif
          end else begin
            stab_cnt <= stab_cnt + BW'(1);
          end
        end
        HELD: begin
          if (!col_on) begin
            stab_cnt <= '0;
            state    <= RELEASE;
`ifdef AUTOREPEAT_EN
            rep_cnt   <= '0;
            repeating <= 1'b0;
          end else if (rep_cnt == rep_last) begin
            bus.key_valid <= 1'b1;
            rep_cnt       <= '0;
            repeating     <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + PW'(1);
`endif
          end
        end
        RELEASE: begin
          if (col_on) begin
            stab_cnt <= '0;
          end else if (stab_cnt == BW'(DEB_CYCLES-1)) begin
            bus.press    <= 1'b0;
            bus.key_code <= NONE;
            row_idx      <= next_row;
            bus.rows     <= ROWS'(1) << next_row;
            dwell_cnt    <= '0;
            state        <= SCAN;
          end else begin
            stab_cnt <= stab_cnt + BW'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end
endmodule
